// File: rtl/ultra_pkg.sv
// ============================================================================
// Module  : ultra_pkg
// Purpose : Shared FSM state type and clock-derived timing helpers for the
//           ultrasonic scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ultra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_STORE     = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    // Round-trip echo time for one centimetre of range.
    localparam int US_PER_CM = 58;

    function automatic int cycles_per_us(input int clk_hz);
        return clk_hz / 1000000;
    endfunction

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return cycles_per_us(clk_hz) * us;
    endfunction

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int cm_to_cycles(input int clk_hz);
        return us_to_cycles(clk_hz, US_PER_CM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/echo_sync.sv
// ============================================================================
// Module  : echo_sync
// Purpose : Two-flop synchroniser for the raw echo inputs with rise/fall
//           pulses generated from the synchronised level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/ultrasonic_scanner.sv
// ============================================================================
// Module  : ultrasonic_scanner
// Purpose : Round-robin HC-SR04 style scanner: triggers each channel, times
//           the echo into centimetres and keeps sticky per-channel results.
//           Optional proximity alarm with macro ULTRASONIC_ALARM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ultrasonic_scanner
    import ultra_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int N_CH       = 4,
    parameter int CM_W       = 16,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_MS     = 60
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [N_CH-1:0]                        echo,
    output logic [N_CH-1:0]                        trigger,
    output logic [N_CH*CM_W-1:0]                   cm,
    output logic [N_CH-1:0]                        valid,
    output logic [N_CH-1:0]                        timeout,
    output logic                                   done,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_idx
`ifdef ULTRASONIC_ALARM_EN
    ,
    input  logic [CM_W-1:0]                        thresh,
    output logic [N_CH-1:0]                        near
`endif
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [31:0]     c_trig_last = 32'(us_to_cycles(CLK_HZ, TRIG_US) - 1);
    localparam logic [31:0]     c_tmo_last  = 32'(us_to_cycles(CLK_HZ, TIMEOUT_US) - 1);
    localparam logic [31:0]     c_gap_last  = 32'(ms_to_cycles(CLK_HZ, GAP_MS) - 1);
    localparam logic [31:0]     c_cm_last   = 32'(cm_to_cycles(CLK_HZ) - 1);
    localparam logic [CH_W-1:0] c_ch_max    = CH_W'(N_CH - 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic [CH_W-1:0] r_ch;
    logic [31:0]     r_timer;
    logic [31:0]     r_sub;
    logic [CM_W-1:0] r_acc;
    logic            r_tmo;
    logic            w_tmo_nx;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic            w_rise_ch;
    logic            w_fall_ch;
    logic            w_timer_clr;
    logic            w_gap_end;

    echo_sync #(
        .WIDTH (N_CH)
    ) u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .din   (echo),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_rise_ch = w_rise[r_ch];
    assign w_fall_ch = w_fall[r_ch];
    assign w_gap_end = (r_state == ST_GAP) && (r_timer == c_gap_last);

    always_comb begin
        w_state_nx = r_state;
        w_tmo_nx   = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nx = ST_TRIG;
            end
            ST_TRIG: begin
                if (r_timer == c_trig_last) w_state_nx = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (w_rise_ch) begin
                    w_state_nx = ST_MEASURE;
                end else if (r_timer == c_tmo_last) begin
                    w_state_nx = ST_STORE;
                    w_tmo_nx   = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (w_fall_ch) begin
                    w_state_nx = ST_STORE;
                    w_tmo_nx   = 1'b0;
                end else if (r_timer == c_tmo_last) begin
                    w_state_nx = ST_STORE;
                    w_tmo_nx   = 1'b1;
                end
            end
            ST_STORE: begin
                w_state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_end) w_state_nx = enable ? ST_TRIG : ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // The timeout budget spans WAIT_RISE and MEASURE, so that hop keeps counting.
    assign w_timer_clr = (w_state_nx != r_state) &&
                         !((r_state == ST_WAIT_RISE) && (w_state_nx == ST_MEASURE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_timer <= '0;
            r_sub   <= '0;
            r_acc   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tmo   <= w_tmo_nx;

            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_state != ST_IDLE) begin
                r_timer <= r_timer + 32'd1;
            end

            // The fall-detect cycle is counted too; it balances the rise-detect cycle.
            if (r_state == ST_MEASURE) begin
                if (r_sub == c_cm_last) begin
                    r_sub <= '0;
                    if (r_acc != '1) r_acc <= r_acc + 1'b1;
                end else begin
                    r_sub <= r_sub + 32'd1;
                end
            end else begin
                r_sub <= '0;
                r_acc <= '0;
            end

            if (w_gap_end) r_ch <= (r_ch == c_ch_max) ? '0 : r_ch + 1'b1;
        end
    end

    always_comb begin
        trigger = '0;
        if (r_state == ST_TRIG) trigger[r_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cm      <= '0;
            valid   <= '0;
            timeout <= '0;
            done    <= 1'b0;
            ch_idx  <= '0;
`ifdef ULTRASONIC_ALARM_EN
            near    <= '0;
`endif
        end else begin
            done <= (r_state == ST_STORE);
            if (r_state == ST_STORE) begin
                ch_idx <= r_ch;
                for (int i = 0; i < N_CH; i++) begin
                    if (r_ch == CH_W'(i)) begin
                        cm[i*CM_W +: CM_W] <= r_tmo ? '0 : r_acc;
                        valid[i]           <= ~r_tmo;
                        timeout[i]         <= r_tmo;
`ifdef ULTRASONIC_ALARM_EN
                        near[i]            <= ~r_tmo && (r_acc < thresh);
`endif
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_scanner.sv
// ============================================================================
// Module  : tb_ultrasonic_scanner
// Purpose : Self-checking bench for ultrasonic_scanner (N_CH=2, GAP_MS=1),
//           plus a CM_W=8 instance for accumulator saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ultrasonic_scanner;

    localparam int CLK_HZ   = 50000000;
    localparam int N_CH     = 2;
    localparam int CM_W     = 16;
    localparam int CM_W_SAT = 8;
    localparam int GAP_MS   = 1;
    localparam int CYC_US   = 50;
    localparam int TRIG_CYC = 500;
    localparam int TMO_CYC  = 1500000;
    localparam int GAP_CYC  = 50000;

    typedef struct {
        int ch;
        int delay_us;
        int width_us;
        int exp_cm;
        bit exp_valid;
        bit exp_tmo;
        bit exp_near;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [N_CH-1:0]      echo;
    logic [N_CH-1:0]      trigger;
    logic [N_CH*CM_W-1:0] cm;
    logic [N_CH-1:0]      valid;
    logic [N_CH-1:0]      timeout;
    logic                 done;
    logic [0:0]           ch_idx;

    logic                     reset_sat;
    logic                     enable_sat;
    logic [N_CH-1:0]          echo_sat;
    logic [N_CH-1:0]          trigger_sat;
    logic [N_CH*CM_W_SAT-1:0] cm_sat;
    logic [N_CH-1:0]          valid_sat;
    logic [N_CH-1:0]          timeout_sat;
    logic                     done_sat;
    logic [0:0]               ch_idx_sat;

`ifdef ULTRASONIC_ALARM_EN
    logic [CM_W-1:0]     thresh;
    logic [N_CH-1:0]     near;
    logic [CM_W_SAT-1:0] thresh_sat;
    logic [N_CH-1:0]     near_sat;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_cm    [N_CH];
    bit m_valid [N_CH];
    bit m_tmo   [N_CH];

    always #10 clk = ~clk;

    ultrasonic_scanner #(
        .CLK_HZ (CLK_HZ), .N_CH (N_CH), .CM_W (CM_W), .GAP_MS (GAP_MS)
    ) u_dut (
        .clk (clk), .reset (reset), .enable (enable), .echo (echo),
        .trigger (trigger), .cm (cm), .valid (valid), .timeout (timeout),
        .done (done), .ch_idx (ch_idx)
`ifdef ULTRASONIC_ALARM_EN
        , .thresh (thresh), .near (near)
`endif
    );

    ultrasonic_scanner #(
        .CLK_HZ (CLK_HZ), .N_CH (N_CH), .CM_W (CM_W_SAT), .GAP_MS (GAP_MS)
    ) u_sat (
        .clk (clk), .reset (reset_sat), .enable (enable_sat), .echo (echo_sat),
        .trigger (trigger_sat), .cm (cm_sat), .valid (valid_sat), .timeout (timeout_sat),
        .done (done_sat), .ch_idx (ch_idx_sat)
`ifdef ULTRASONIC_ALARM_EN
        , .thresh (thresh_sat), .near (near_sat)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_any_trig(input int max_cyc, output int idx);
        int n = 0;
        idx = -1;
        while (idx < 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (trigger != '0) idx = trigger[1] ? 1 : 0;
        end
    endtask

    // Entered on the negedge where trigger[idx] was first seen high.
    task automatic measure_trig(input int idx, output int width, output bit other);
        width = 0;
        other = 1'b0;
        while (trigger[idx] === 1'b1 && width < 100000) begin
            width++;
            if (trigger[1-idx] !== 1'b0) other = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int max_cyc, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_echo(input int ch, input int delay_us, input int width_us);
        repeat (delay_us * CYC_US) @(posedge clk);
        #1 echo[ch] = 1'b1;
        repeat (width_us * CYC_US) @(posedge clk);
        #1 echo[ch] = 1'b0;
    endtask

    task automatic check_result(input vec_t v, input string tag);
        int other;
        check({tag, "_ch_idx"},  64'(ch_idx), 64'(v.ch));
        check({tag, "_cm"},      64'(cm[v.ch*CM_W +: CM_W]), 64'(v.exp_cm));
        check({tag, "_valid"},   64'(valid[v.ch]), 64'(v.exp_valid));
        check({tag, "_timeout"}, 64'(timeout[v.ch]), 64'(v.exp_tmo));
`ifdef ULTRASONIC_ALARM_EN
        check({tag, "_near"},    64'(near[v.ch]), 64'(v.exp_near));
`endif
        m_cm[v.ch]    = v.exp_cm;
        m_valid[v.ch] = v.exp_valid;
        m_tmo[v.ch]   = v.exp_tmo;
        other = 1 - v.ch;
        check({tag, "_hold_cm"},      64'(cm[other*CM_W +: CM_W]), 64'(m_cm[other]));
        check({tag, "_hold_valid"},   64'(valid[other]), 64'(m_valid[other]));
        check({tag, "_hold_timeout"}, 64'(timeout[other]), 64'(m_tmo[other]));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int idx, w, lat;
        bit other, ok;
        wait_any_trig(200000, idx);
        check({tag, "_trig_ch"}, 64'(idx), 64'(v.ch));
        if (idx >= 0) begin
            measure_trig(idx, w, other);
            check({tag, "_trig_width"}, 64'(w), 64'(TRIG_CYC));
            check({tag, "_trig_other"}, 64'(other), 64'd0);
            if (v.width_us > 0) pulse_echo(v.ch, v.delay_us, v.width_us);
            wait_done(TMO_CYC + 1000, lat, ok);
            check({tag, "_done_seen"}, 64'(ok), 64'd1);
            if (v.width_us == 0)
                check({tag, "_tmo_latency_ok"}, 64'(lat >= TMO_CYC - 10 && lat <= TMO_CYC + 10), 64'd1);
            if (ok) check_result(v, tag);
        end
    endtask

    task automatic run_main();
        vec_t vecs [4];
        vec_t vd;
        int idx, w, lat, seen;
        bit other, ok;

        vecs[0] = '{0, 100,  580, 10, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1,   0,    0,  0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{0, 100, 1750, 30, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1,  50,  290,  5, 1'b1, 1'b0, 1'b1};

        @(posedge clk);
        #1 enable = 1'b1;
        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Dropping enable mid-measurement still stores ch0 and then idles.
        wait_any_trig(200000, idx);
        check("drop_trig_ch", 64'(idx), 64'd0);
        if (idx == 0) begin
            measure_trig(0, w, other);
            repeat (100 * CYC_US) @(posedge clk);
            #1 echo[0] = 1'b1;
            repeat (1000) @(posedge clk);
            #1 enable = 1'b0;
            repeat (580 * CYC_US - 1000) @(posedge clk);
            #1 echo[0] = 1'b0;
            wait_done(2000, lat, ok);
            check("drop_done_seen", 64'(ok), 64'd1);
            vd = '{0, 100, 580, 10, 1'b1, 1'b0, 1'b1};
            if (ok) check_result(vd, "drop");
            seen = 0;
            for (int i = 0; i < GAP_CYC + 10000; i++) begin
                @(negedge clk);
                if (trigger != '0) seen++;
            end
            check("drop_no_trigger", 64'(seen), 64'd0);
        end

        // Reset in the middle of a ch1 measurement.
        check("pre_rst_valid", 64'(valid), 64'd3);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_any_trig(1000, idx);
        check("rst_trig_ch", 64'(idx), 64'd1);
        if (idx == 1) begin
            measure_trig(1, w, other);
            repeat (100 * CYC_US) @(posedge clk);
            #1 echo[1] = 1'b1;
            repeat (2000) @(posedge clk);
            #5 reset = 1'b0;
            #1;
            check("rst_trigger", 64'(trigger), 64'd0);
            check("rst_valid",   64'(valid),   64'd0);
            check("rst_timeout", 64'(timeout), 64'd0);
            check("rst_done",    64'(done),    64'd0);
            check("rst_ch_idx",  64'(ch_idx),  64'd0);
            check("rst_cm",      64'(cm),      64'd0);
            echo[1] = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            wait_any_trig(1000, idx);
            check("post_rst_trig_ch", 64'(idx), 64'd0);
            repeat (100) @(posedge clk);
            #5 reset = 1'b0;
            #1 check("rst_drops_trigger", 64'(trigger), 64'd0);
            @(posedge clk);
            #1 reset = 1'b1;
            wait_any_trig(1000, idx);
            check("rerun_trig_ch", 64'(idx), 64'd0);
            if (idx == 0) begin
                measure_trig(0, w, other);
                check("rerun_trig_width", 64'(w), 64'(TRIG_CYC));
            end
        end
    endtask

    task automatic run_sat();
        int n;
        bit ok;
        @(posedge clk);
        #1 enable_sat = 1'b1;
        n = 0;
        while (trigger_sat[0] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check("sat_trig_seen", 64'(trigger_sat[0]), 64'd1);
        n = 0;
        while (trigger_sat[0] === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check("sat_trig_width", 64'(n), 64'(TRIG_CYC));
        repeat (100 * CYC_US) @(posedge clk);
        #1 echo_sat[0] = 1'b1;
        repeat (20000 * CYC_US) @(posedge clk);
        #1 echo_sat[0] = 1'b0;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            n++;
            if (done_sat === 1'b1) ok = 1'b1;
        end
        check("sat_done_seen", 64'(ok), 64'd1);
        check("sat_cm",      64'(cm_sat[CM_W_SAT-1:0]), 64'd255);
        check("sat_valid",   64'(valid_sat[0]), 64'd1);
        check("sat_timeout", 64'(timeout_sat[0]), 64'd0);
        check("sat_ch_idx",  64'(ch_idx_sat), 64'd0);
        enable_sat = 1'b0;
    endtask

    initial begin
        int seen;
        reset      = 1'b0;
        reset_sat  = 1'b0;
        enable     = 1'b0;
        enable_sat = 1'b0;
        echo       = '0;
        echo_sat   = '0;
`ifdef ULTRASONIC_ALARM_EN
        thresh     = CM_W'(20);
        thresh_sat = '0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            m_cm[i]    = 0;
            m_valid[i] = 1'b0;
            m_tmo[i]   = 1'b0;
        end

        repeat (4) @(negedge clk);
        check("reset_trigger", 64'(trigger), 64'd0);
        check("reset_cm",      64'(cm),      64'd0);
        check("reset_valid",   64'(valid),   64'd0);
        check("reset_timeout", 64'(timeout), 64'd0);
        check("reset_done",    64'(done),    64'd0);
        check("reset_ch_idx",  64'(ch_idx),  64'd0);
        check("reset_sat_cm",  64'(cm_sat),  64'd0);

        @(posedge clk);
        #1;
        reset     = 1'b1;
        reset_sat = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trigger != '0) seen++;
        end
        check("idle_no_trigger", 64'(seen), 64'd0);

        fork
            run_main();
            run_sat();
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ultrasonic_scanner.md
ULTRASONIC_SCANNER -- requirements
Module: ultrasonic_scanner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4, number of sensor channels (1..8).
REQ-003 SHALL have parameter CM_W, default 16, width of each distance result.
REQ-004 SHALL have parameter TRIG_US, default 10, trigger pulse width in µs.
REQ-005 SHALL have parameter TIMEOUT_US, default 30000, maximum wait for the echo rise and the echo high time, in µs.
REQ-006 SHALL have parameter GAP_MS, default 60, dead time after each channel before the next trigger, in ms.
REQ-007 SHALL have ports:
  clk  in  1  system clock, rising edge
  reset  in  1  asynchronous, active-low reset
  enable  in  1  1 = scanning runs; 0 = stop after the current channel
  echo  in  N_CH  raw echo inputs, asynchronous
  trigger  out  N_CH  per-channel trigger pulses
  cm  out  N_CH*CM_W  per-channel distance in cm; channel i at bits [i*CM_W +: CM_W]
  valid  out  N_CH  sticky; set when channel i holds a good result
  timeout  out  N_CH  sticky; set when channel i's last attempt timed out
  done  out  1  one-cycle pulse when a channel finishes
  ch_idx  out  $clog2(N_CH) (min 1)  channel just finished, valid with done

Function
REQ-008 Each echo bit SHALL pass through a 2-flop synchroniser; all FSM decisions SHALL use the synchronised value.
REQ-009 FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, STORE, GAP.
REQ-010 IDLE -> TRIG when enable=1; the active channel starts at 0 after reset.
REQ-011 TRIG SHALL drive trigger[ch]=1 for exactly CLK_HZ/1e6*TRIG_US cycles (500 at default), then go to WAIT_RISE; all other trigger bits stay 0.
REQ-012 WAIT_RISE -> MEASURE on a synchronised echo rising edge. An echo already high on entry SHALL NOT count as a rise.
REQ-013 MEASURE: a sub-counter SHALL wrap every CLK_HZ*58/1e6 cycles (2900 at default) and increment the cm accumulator on each wrap; the accumulator SHALL saturate at 2^CM_W-1.
REQ-014 MEASURE -> STORE on the synchronised echo falling edge.
REQ-015 Timeout: if WAIT_RISE plus MEASURE time reaches TIMEOUT_US, the FSM SHALL go to STORE with timeout status.
REQ-016 STORE (one cycle):
  good result: cm[ch] = accumulator, valid[ch]=1, timeout[ch]=0
  timeout: cm[ch] = 0, valid[ch]=0, timeout[ch]=1
  both cases: done=1, ch_idx=ch
REQ-017 GAP SHALL last GAP_MS ms. The channel then advances ch = (ch+1) mod N_CH (N_CH-1 wraps to 0). Exit to TRIG if enable=1, else to IDLE.
REQ-018 Deasserting enable mid-channel SHALL NOT abort it; the result is stored and the GAP completes first.
REQ-019 Other channels' cm/valid/timeout SHALL hold their values while channel ch is serviced.

Reset
REQ-020 reset=0 SHALL asynchronously force:
  state IDLE, ch=0
  trigger, valid, timeout, done, ch_idx, cm all 0
  all counters and synchroniser flops 0
REQ-021 Reset mid-measurement SHALL discard the partial result and drop trigger immediately.

Configuration
REQ-022 With macro ULTRASONIC_ALARM_EN defined, the block SHALL add:
  input thresh (CM_W bits)
  output near (N_CH bits)
  near[i] registered in STORE as valid-result && cm < thresh; cleared on timeout and by reset.
REQ-023 Without ULTRASONIC_ALARM_EN, thresh, near and their logic SHALL be absent.

Structure
REQ-024 Package ultra_pkg SHALL hold:
  FSM state typedef
  µs-per-cm constant 58
  cycle-count helper functions derived from CLK_HZ
REQ-025 Sub-module echo_sync (parametrised-width 2-flop synchroniser plus rise/fall edge detect) SHALL be instantiated once for all N_CH bits.

Verification
REQ-026 Bench SHALL run CLK_HZ=50000000, N_CH=2, GAP_MS=1 and cover:
  single reading: echo0 high 580 µs, starting 100 µs after trigger falls -> trigger0 high 500 cycles; cm[0]=10, valid[0]=1, done pulse with ch_idx=0
  silent sensor: echo1 never rises -> after 30000 µs, timeout[1]=1, valid[1]=0, cm[1]=0; channel then wraps to 0
  saturation: CM_W=8, echo0 high 20000 µs -> cm[0]=255 (saturated; 344 cm unsaturated), valid[0]=1
  enable drop: enable=0 during MEASURE on ch0 -> result stored, GAP completed, IDLE entered, no trigger1 issued
  reset mid-run: reset=0 during MEASURE -> all outputs 0 within the same cycle; after release with enable=1, trigger0 is next
  alarm build: ULTRASONIC_ALARM_EN defined, thresh=20 -> near[0]=1 for 10 cm, 0 for 30 cm
